shift_right_seq: RTL and testbench

- Multi-cycle right shifter for the MIPS datapath; the right-shift counterpart of the left-shift-by-2 block.
- Executes SRL/SRA/SRLV/SRAV: shifts a 32-bit operand right by 0-31 bits, STEP bits per cycle.
- Operands arrive on a valid/ready input handshake. The result is held on a valid/ready output handshake until consumed.
- Sits beside the ALU, driven by the execute-stage controller.

---
 rtl/mips_shift_pkg.sv | 25 ++
 rtl/shift_right_step.sv | 32 +++
 rtl/shift_right_seq.sv | 112 +++++++++++
 tb/tb_shift_right_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_shift_pkg.sv
// Shared types and constants for the sequential MIPS right shifter.
// Holds the FSM encoding and the legal per-cycle step sizes.
package mips_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shr_state_t;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam int STEP_SET [4] = '{1, 2, 4, 8};

  function automatic bit step_legal(int s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (STEP_SET[i] == s) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/shift_right_step.sv
// One cycle of right shift by k (1..STEP) with a fixed fill bit.
// k == 0 passes work through unchanged.
module shift_right_step
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] work,
  input  logic             fill,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] nxt,
  output logic             last
);

  logic [WIDTH-1:0] ones;

  always_comb begin
    ones = '1;
    nxt  = work;
    last = 1'b0;
    for (int j = 1; j <= STEP; j++) begin
      if (k == KW'(j)) begin
        nxt  = (work >> j) |
               (fill ? ~(ones >> j) : '0);
        last = work[j-1];
      end
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA shifter, STEP bits per cycle,
// valid/ready on both sides; result held until consumed.
module shift_right_seq
  import mips_shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last_bit,
  output logic               busy
);

  localparam int KW = $clog2(STEP + 1);

  if (!step_legal(STEP)) begin : g_bad_step
    $error("shift_right_seq: STEP must be 1, 2, 4 or 8");
  end

  shr_state_t         state;
  shr_state_t         state_nxt;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] rem;
  logic               fill;
  logic               last_bit;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_work;
  logic               step_last;
  logic               accept;

  assign accept = in_valid && (state == IDLE);

  // Final step may be shorter than STEP.
  always_comb begin
    k = KW'(STEP);
    if (rem < SHAMT_W'(STEP)) k = KW'(rem);
  end

  shift_right_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .work (work),
    .fill (fill),
    .k    (k),
    .nxt  (step_work),
    .last (step_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_shamt == '0) state_nxt = DONE;
          else                state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (rem == SHAMT_W'(k)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      rem      <= '0;
      fill     <= 1'b0;
      last_bit <= 1'b0;
    end else if (accept) begin
      work     <= in_data;
      rem      <= in_shamt;
      fill     <= in_arith & in_data[WIDTH-1];
      last_bit <= 1'b0;
    end else if (state == SHIFT) begin
      work     <= step_work;
      rem      <= rem - SHAMT_W'(k);
      last_bit <= step_last;
    end
  end

  assign out_data     = work;
  assign out_last_bit = last_bit;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: STEP=1 and STEP=4 instances share
// stimulus; a transaction-level model is checked every cycle.
module tb_shift_right_seq;

  localparam int STEPS [2] = '{1, 4};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        out_ready;

  logic        rdy [2];
  logic        ov  [2];
  logic [31:0] od  [2];
  logic        olb [2];
  logic        bsy [2];

  int checks;
  int errors;

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (rdy[0]),
    .in_data      (in_data),
    .in_shamt     (in_shamt),
    .in_arith     (in_arith),
    .out_valid    (ov[0]),
    .out_ready    (out_ready),
    .out_data     (od[0]),
    .out_last_bit (olb[0]),
    .busy         (bsy[0])
  );

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_s4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (rdy[1]),
    .in_data      (in_data),
    .in_shamt     (in_shamt),
    .in_arith     (in_arith),
    .out_valid    (ov[1]),
    .out_ready    (out_ready),
    .out_data     (od[1]),
    .out_last_bit (olb[1]),
    .busy         (bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sra(logic [31:0] d, int s);
    logic signed [31:0] t;
    t = $signed(d);
    t = t >>> s;
    return t;
  endfunction

  // Transaction model: result and latency from the operand alone.
  logic        m_busy [2];
  int          m_cnt  [2];
  logic [31:0] m_res  [2];
  logic        m_lb   [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_res[i]  <= '0;
        m_lb[i]   <= 1'b0;
      end else if (!m_busy[i]) begin
        if (in_valid) begin
          m_busy[i] <= 1'b1;
          m_cnt[i]  <= (int'(in_shamt) + STEPS[i] - 1) / STEPS[i];
          m_res[i]  <= in_arith ? sra(in_data, int'(in_shamt))
                                : in_data >> in_shamt;
          if (in_shamt == 0) m_lb[i] <= 1'b0;
          else               m_lb[i] <= in_data[in_shamt - 5'd1];
        end
      end else if (m_cnt[i] > 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
      end else if (out_ready) begin
        m_busy[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc_in_ready%0d", i), 32'(rdy[i]),
            32'(!m_busy[i]));
      check($sformatf("cyc_busy%0d", i), 32'(bsy[i]),
            32'(m_busy[i]));
      check($sformatf("cyc_out_valid%0d", i), 32'(ov[i]),
            32'(m_busy[i] && m_cnt[i] == 0));
      if (m_busy[i] && m_cnt[i] == 0) begin
        check($sformatf("cyc_out_data%0d", i), od[i], m_res[i]);
        check($sformatf("cyc_last_bit%0d", i), 32'(olb[i]),
              32'(m_lb[i]));
      end
    end
  end

  int lat [2];

  task automatic issue(logic [31:0] d, logic [4:0] sh,
                       logic ar);
    in_data  = d;
    in_shamt = sh;
    in_arith = ar;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    lat[0] = -1;
    lat[1] = -1;
    for (int c = 0; c <= 40; c++) begin
      for (int i = 0; i < 2; i++)
        if (ov[i] && lat[i] < 0) lat[i] = c;
      if (lat[0] >= 0 && lat[1] >= 0) break;
      @(posedge clk);
      #1;
    end
    if (lat[0] < 0 || lat[1] < 0) begin
      errors++;
      $display("FAIL wait_done timeout act=%0d,%0d exp=valid",
               lat[0], lat[1]);
    end
  endtask

  task automatic expect_res(int i, string nm, logic [31:0] d,
                            logic lb, int l);
    check({nm, "_data"}, od[i], d);
    check({nm, "_last"}, 32'(olb[i]), 32'(lb));
    check({nm, "_lat"}, 32'(lat[i]), 32'(l));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("pop_ready0", 32'(rdy[0]), 32'd1);
    check("pop_ready1", 32'(rdy[1]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_ready", 32'(rdy[0]), 32'd1);
    check("rst_valid", 32'(ov[0]), 32'd0);
    check("rst_data", od[0], 32'h0);
    check("rst_busy", 32'(bsy[1]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h1234_5678, 5'd0, 1'b0);
    wait_done();
    expect_res(0, "sh0_s1", 32'h1234_5678, 1'b0, 0);
    expect_res(1, "sh0_s4", 32'h1234_5678, 1'b0, 0);
    pop();

    issue(32'h8000_000F, 5'd4, 1'b0);
    wait_done();
    expect_res(0, "srl4_s1", 32'h0800_0000, 1'b1, 4);
    expect_res(1, "srl4_s4", 32'h0800_0000, 1'b1, 1);
    pop();

    issue(32'h8000_0000, 5'd31, 1'b1);
    wait_done();
    expect_res(0, "sra31_s1", 32'hFFFF_FFFF, 1'b0, 31);
    expect_res(1, "sra31_s4", 32'hFFFF_FFFF, 1'b0, 8);
    pop();

    issue(32'h8000_0000, 5'd31, 1'b0);
    wait_done();
    expect_res(0, "srl31_s1", 32'h0000_0001, 1'b0, 31);
    pop();

    issue(32'hF000_00A5, 5'd5, 1'b1);
    wait_done();
    expect_res(1, "sra5_s4", 32'hFF80_0005, 1'b0, 2);
    expect_res(0, "sra5_s1", 32'hFF80_0005, 1'b0, 5);

    // Backpressure with a competing operand presented.
    in_data  = 32'hDEAD_BEEF;
    in_shamt = 5'd3;
    in_arith = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_data", od[1], 32'hFF80_0005);
      check("bp_ready", 32'(rdy[1]), 32'd0);
      check("bp_valid", 32'(ov[0]), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_pop_ready", 32'(rdy[0]), 32'd1);
    check("bp_pop_busy", 32'(bsy[1]), 32'd0);
    @(posedge clk);
    #1;
    check("bp_no_accept", 32'(bsy[0]), 32'd0);

    // Asynchronous reset mid-shift.
    issue(32'h7654_3210, 5'd20, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", 32'(bsy[0]), 32'd1);
    check("mid_ready", 32'(rdy[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid0", 32'(ov[0]), 32'd0);
    check("ar_busy0", 32'(bsy[0]), 32'd0);
    check("ar_ready0", 32'(rdy[0]), 32'd1);
    check("ar_valid1", 32'(ov[1]), 32'd0);
    check("ar_ready1", 32'(rdy[1]), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'hDEAD_BEEF, 5'd8, 1'b0);
    wait_done();
    expect_res(0, "post_s1", 32'h00DE_ADBE, 1'b1, 8);
    expect_res(1, "post_s4", 32'h00DE_ADBE, 1'b1, 2);
    pop();

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
